// File: rtl/bcd_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : bcd_pkg                                                    |
// | Brief   : Shared constants and FSM state type for the BCD converter. |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
package bcd_pkg;

  localparam int DIGIT_W = 4;

  localparam logic [1:0] MODE_8421 = 2'd0;
  localparam logic [1:0] MODE_XS3  = 2'd1;
  localparam logic [1:0] MODE_2421 = 2'd2;
  localparam logic [1:0] MODE_5421 = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_ENCODE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // Saturates rather than wraps so the size check stays meaningful for big DIGITS.
  function automatic longint unsigned pow10(input int n);
    longint unsigned v;
    v = 64'd1;
    for (int i = 0; i < n; i++) begin
      if (v > 64'd1844674407370955161) v = 64'hFFFF_FFFF_FFFF_FFFF;
      else v = v * 64'd10;
    end
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_digit_encoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : bcd_digit_encoder                                          |
// | Brief   : Maps one decimal digit to 8421 / XS-3 / 2421 / 5421 code.  |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module bcd_digit_encoder
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit,
  input  logic [1:0]         mode,
  output logic [DIGIT_W-1:0] code
);

  logic w_valid_digit;
  logic w_high_digit;

  assign w_valid_digit = (digit <= 4'd9);
  assign w_high_digit  = (digit >= 4'd5);

  // Non-decimal inputs pass through unchanged in every mode.
  always_comb begin
    code = digit;
    if (w_valid_digit) begin
      case (mode)
        MODE_8421: code = digit;
        MODE_XS3:  code = digit + 4'd3;
        MODE_2421: code = w_high_digit ? digit + 4'd6 : digit;
        MODE_5421: code = w_high_digit ? digit + 4'd3 : digit;
        default:   code = digit;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/bin2bcd_code_converter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : bin2bcd_code_converter                                     |
// | Brief   : Sequential double-dabble converter with per-digit encoder. |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module bin2bcd_code_converter
  import bcd_pkg::*;
#(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [BIN_W-1:0]          in_bin,
  input  logic [1:0]                in_mode,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DIGIT_W*DIGITS-1:0] out_data,
  output logic [1:0]                out_mode,
  output logic                      busy
);

  localparam int CNT_W = (BIN_W < 2) ? 1 : $clog2(BIN_W + 1);
  localparam int BCD_W = DIGIT_W * DIGITS;
  localparam logic [CNT_W-1:0] C_LAST_ITER = CNT_W'(BIN_W - 1);

  if (pow10(DIGITS) < (64'd1 << BIN_W)) begin : g_size_check
    $error("bin2bcd_code_converter: DIGITS=%0d too small for BIN_W=%0d", DIGITS, BIN_W);
  end

  state_t             r_state;
  state_t             w_state_nxt;
  logic [BIN_W-1:0]   r_bin;
  logic [BCD_W-1:0]   r_bcd;
  logic [CNT_W-1:0]   r_cnt;
  logic [1:0]         r_mode;
  logic               r_out_valid;
  logic [BCD_W-1:0]   r_out_data;
  logic [1:0]         r_out_mode;
  logic [BCD_W-1:0]   w_bcd_adj;
  logic [BCD_W-1:0]   w_code;
  logic [BCD_W+BIN_W-1:0] w_shift;
  logic               w_in_ready;
  logic               w_busy;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    assign w_bcd_adj[g*DIGIT_W +: DIGIT_W] =
      (r_bcd[g*DIGIT_W +: DIGIT_W] >= 4'd5) ? r_bcd[g*DIGIT_W +: DIGIT_W] + 4'd3
                                            : r_bcd[g*DIGIT_W +: DIGIT_W];

    bcd_digit_encoder u_enc (
      .digit (r_bcd[g*DIGIT_W +: DIGIT_W]),
      .mode  (r_mode),
      .code  (w_code[g*DIGIT_W +: DIGIT_W])
    );
  end

  assign w_shift = {w_bcd_adj, r_bin} << 1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_busy      = 1'b1;
    case (r_state)
      ST_IDLE: begin
        w_in_ready = 1'b1;
        w_busy     = 1'b0;
        if (in_valid) w_state_nxt = ST_SHIFT;
      end
      ST_SHIFT:  if (r_cnt == C_LAST_ITER) w_state_nxt = ST_ENCODE;
      ST_ENCODE: w_state_nxt = ST_DONE;
      ST_DONE:   if (out_ready) w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bin       <= '0;
      r_bcd       <= '0;
      r_cnt       <= '0;
      r_mode      <= MODE_8421;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_mode  <= MODE_8421;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_bin  <= in_bin;
            r_mode <= in_mode;
            r_bcd  <= '0;
            r_cnt  <= '0;
          end
        end
        ST_SHIFT: begin
          r_bcd <= w_shift[BCD_W+BIN_W-1:BIN_W];
          r_bin <= w_shift[BIN_W-1:0];
          r_cnt <= r_cnt + CNT_W'(1);
        end
        ST_ENCODE: begin
          r_out_data  <= w_code;
          r_out_mode  <= r_mode;
          r_out_valid <= 1'b1;
        end
        ST_DONE: begin
          if (out_ready) r_out_valid <= 1'b0;
        end
        default: r_out_valid <= 1'b0;
      endcase
    end
  end

  assign in_ready  = w_in_ready;
  assign busy      = w_busy;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_mode  = r_out_mode;

endmodule
`default_nettype wire

// File: doc/bin2bcd_code_converter.md
Name: bin2bcd_code_converter

Overview:
- Sequential, parametrised successor to the team's 4-bit combinational BCD code converter.
- Converts a BIN_W-bit unsigned binary value into DIGITS decimal digits using shift-and-add-3 (double-dabble), one iteration per clock.
- Then encodes every digit into a selectable 4-bit decimal code: 8421, excess-3, 2421 (Aiken) or 5421.
- Sits between a binary datapath (counter/ALU) and display/code-output logic; valid/ready handshake on both sides.

Parameters:
- BIN_W, 8, width of binary input (>=1).
- DIGITS, 3, number of output decimal digits. Elaboration-time check is mandatory: $error if 10^DIGITS < 2^BIN_W.

Ports:
- clk  input  1  sole clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input word valid.
- in_ready  output  1  converter can accept a word.
- in_bin  input  BIN_W  unsigned binary value.
- in_mode  input  2  code select: 0=8421, 1=excess-3, 2=2421, 3=5421.
- out_valid  output  1  out_data valid.
- out_ready  input  1  consumer accepts out_data.
- out_data  output  4*DIGITS  encoded digits, digit 0 (units) in [3:0].
- out_mode  output  2  mode used for the current out_data.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: in_ready=1, out_valid=0, out_data=0, out_mode=0, busy=0; FSM=IDLE; internal shift register and iteration counter cleared.
- Reset mid-operation: assertion at any time aborts the conversion immediately; no partial result is ever presented.
- FSM states: IDLE, SHIFT, ENCODE, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready at edge E0: latch in_bin and in_mode, clear BCD digits and counter, go to SHIFT.
- SHIFT:
  - in_ready=0.
  - Each edge: first add 3 to every BCD digit >=5, then shift {bcd,bin} left by 1 and increment the counter.
  - After BIN_W iterations (edges E1..E_BIN_W), go to ENCODE.
- ENCODE: at edge E_(BIN_W+1), register the encoded digits into out_data, set out_mode to the latched mode, set out_valid=1, go to DONE.
- Latency: out_valid is first high after edge E0+BIN_W+1, i.e. BIN_W+1 cycles after acceptance.
- DONE:
  - out_valid, out_data and out_mode are held stable while out_ready=0 (unbounded backpressure).
  - On out_valid&&out_ready: out_valid=0 at the next edge, go to IDLE.
  - out_data keeps its last value after the transfer.
  - in_ready stays 0 in DONE; no same-cycle accept. Back-to-back throughput is one word per BIN_W+3 cycles.
- in_mode and in_bin changes after acceptance are ignored; the latched values are used.
- in_valid while in_ready=0 is ignored; the word is not consumed.
- Per-digit encoding for digit d (0..9):
  - mode 0: d.
  - mode 1: d+3.
  - mode 2: d for d<5, d+6 for d>=5.
  - mode 3: d for d<5, d+3 for d>=5.
- Digits are always 0..9 after conversion; the encoder output for d>9 is don't-care but must be deterministic (pass-through).
- All arithmetic is 4-bit per digit, with no carry between digits except via the shift.
- Counter width: $clog2(BIN_W+1).

Decomposition:
- Package bcd_pkg:
  - Mode constants MODE_8421, MODE_XS3, MODE_2421, MODE_5421.
  - FSM state typedef/localparams.
  - Digit width constant DIGIT_W=4.
- Sub-module bcd_digit_encoder:
  - Purely combinational, 4-bit digit + 2-bit mode -> 4-bit code.
  - Instantiated DIGITS times via generate.
- The double-dabble step and the FSM stay in the top module.

Test Plan (BIN_W=8, DIGITS=3):
- in_bin=255, mode 0, out_ready=1 -> out_data=0x255, out_valid exactly 9 cycles after the accept edge, out_mode=0.
- in_bin=255, mode 1 -> 0x588. in_bin=0, mode 1 -> 0x333.
- in_bin=97, mode 2 -> 0x0FD. in_bin=68, mode 3 -> 0x09B.
- Backpressure:
  - Stimulus: out_ready=0 for 5 cycles after out_valid, with in_valid=1 and changing in_bin/in_mode throughout.
  - Required: out_data/out_mode stable, in_ready=0, no new word accepted.
  - After out_ready=1: one transfer, then IDLE with in_ready=1.
- Reset mid-conversion:
  - Stimulus: rst_n low asynchronously during SHIFT (counter=4).
  - Required: outputs take reset values immediately; after release, a fresh in_bin=10, mode 0 gives 0x010.
- Exhaustive sweep: in_bin 0..255 in all 4 modes -> out_data matches the reference model; busy high from E0 through the transfer.
